// File: rtl/stream_sel_mux.sv
// Registered N-to-1 valid/ready stream selector with fixed-select and round-robin modes.
// Define STREAM_MUX_BURST_EN to let a round-robin channel keep priority for up to BURST beats.
module stream_sel_mux #(
    parameter int unsigned W     = 4,
    parameter int unsigned N     = 4,
    parameter int unsigned SW    = $clog2(N),
    parameter int unsigned BURST = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                mode,
    input  logic [SW-1:0]       sel,
    input  logic [N-1:0][W-1:0] in_data,
    input  logic [N-1:0]        in_valid,
    output logic [N-1:0]        in_ready,
    output logic [W-1:0]        out_data,
    output logic [SW-1:0]       out_ch,
    output logic                out_valid,
    input  logic                out_ready
);

    if (W < 1 || N < 2 || BURST < 1) begin : g_param_check
        $error("stream_sel_mux: invalid parameter set");
    end

    logic [W-1:0]  out_data_q, out_data_d;
    logic [SW-1:0] out_ch_q, out_ch_d;
    logic          out_valid_q, out_valid_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic          load_en;
    logic          grant_valid;
    logic          xfer;
    logic [SW-1:0] grant;
    logic [SW-1:0] grant_inc;
    logic [SW-1:0] rr_grant;
    logic          rr_found;
    logic [SW-1:0] rr_idx;

    assign load_en = !out_valid_q || out_ready;

    // Round-robin search ptr, ptr+1, ... wrapping at N (N need not be a power of 2).
    always_comb begin
        rr_found = 1'b0;
        rr_grant = '0;
        rr_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            rr_idx = (32'(ptr_q) + i >= N) ? SW'(32'(ptr_q) + i - N) : SW'(32'(ptr_q) + i);
            if (!rr_found && in_valid[rr_idx]) begin
                rr_found = 1'b1;
                rr_grant = rr_idx;
            end
        end
    end

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        if (mode) begin
            grant       = rr_grant;
            grant_valid = rr_found;
        end else if (32'(sel) < N) begin
            grant       = sel;
            grant_valid = in_valid[sel];
        end
    end

    assign xfer      = reset_n && load_en && grant_valid;
    assign grant_inc = (32'(grant) + 1 >= N) ? '0 : grant + 1'b1;

    always_comb begin
        in_ready = '0;
        if (xfer) begin
            in_ready[grant] = 1'b1;
        end
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        if (load_en) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = in_data[grant];
                out_ch_d   = grant;
            end
        end
    end

`ifdef STREAM_MUX_BURST_EN
    localparam int unsigned CW = $clog2(BURST + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // A repeat grant of the pointer channel extends its burst; any other grant starts a new one.
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (xfer) begin
            if (!mode || BURST == 1) begin
                ptr_d = grant_inc;
                cnt_d = '0;
            end else if (grant == ptr_q) begin
                if (32'(cnt_q) + 1 == BURST) begin
                    ptr_d = grant_inc;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                ptr_d = grant;
                cnt_d = CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = grant_inc;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_stream_sel_mux.sv
// Self-checking bench for stream_sel_mux (W=4, N=4) against a behavioural stream model.
module tb_stream_sel_mux;
    localparam int W     = 4;
    localparam int N     = 4;
    localparam int SW    = 2;
    localparam int BURST = 3;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                mode;
    logic [SW-1:0]       sel;
    logic [N-1:0][W-1:0] in_data;
    logic [N-1:0]        in_valid;
    logic [N-1:0]        in_ready;
    logic [W-1:0]        out_data;
    logic [SW-1:0]       out_ch;
    logic                out_valid;
    logic                out_ready;

    int errors = 0;
    int checks = 0;

    // Model: the one-entry output register, the search pointer and the burst count.
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_ch, m_ptr, m_cnt, m_last;

    stream_sel_mux #(.W(W), .N(N), .BURST(BURST)) dut (
        .clk(clk), .reset_n(reset_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic int m_grant();
        if (!mode) return (int'(sel) < N && in_valid[sel]) ? int'(sel) : -1;
        for (int k = 0; k < N; k++) begin
            if (in_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        int g;
        g = m_grant();
        if (!reset_n) return '0;
        if ((!m_valid || out_ready) && g >= 0) return 4'(1 << g);
        return '0;
    endfunction

    task automatic m_advance(input int g);
`ifdef STREAM_MUX_BURST_EN
        if (!mode || BURST == 1) begin
            m_ptr = (g + 1) % N;
            m_cnt = 0;
        end else if (g == m_ptr) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == BURST) begin
                m_ptr = (g + 1) % N;
                m_cnt = 0;
            end
        end else begin
            m_ptr = g;
            m_cnt = 1;
        end
`else
        m_ptr = (g + 1) % N;
`endif
    endtask

    task automatic tick();
        int g;
        @(posedge clk);
        g = m_grant();
        m_last = -1;
        if (!reset_n) begin
            m_valid = 1'b0; m_data = '0; m_ch = 0; m_ptr = 0; m_cnt = 0;
        end else if (!m_valid || out_ready) begin
            if (g >= 0) begin
                m_valid = 1'b1;
                m_data  = in_data[g];
                m_ch    = g;
                m_last  = g;
                m_advance(g);
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; mode = 1'b1; sel = '0; out_ready = 1'b1;
        in_valid = 4'b1111; in_data = 16'h9A5C;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++; $display("FAIL reset_ready: got %b want 0000", in_ready);
            end
            tick();
            checks++;
            if ({out_valid, out_data, out_ch} !== 7'b0) begin
                errors++;
                $display("FAIL reset_out: got valid=%b data=%h ch=%0d want 0/0/0", out_valid, out_data, out_ch);
            end
        end
        reset_n = 1'b1;
    endtask

    task automatic test_fixed();
        do_reset();
        mode = 1'b0; sel = 2'd2; out_ready = 1'b1; in_valid = 4'b1111;
        in_data = {4'hD, 4'hA, 4'hC, 4'hB};
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0100) begin
                errors++; $display("FAIL fixed_ready: got %b want 0100", in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 4'hA || out_ch !== 2'd2) begin
                errors++;
                $display("FAIL fixed_sel2: got valid=%b data=%h ch=%0d want 1/a/2", out_valid, out_data, out_ch);
            end
        end
        sel = 2'd3;
        #1;
        checks++;
        if (in_ready !== 4'b1000) begin
            errors++; $display("FAIL fixed_ready3: got %b want 1000", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 4'hD || out_ch !== 2'd3) begin
            errors++;
            $display("FAIL fixed_sel3: got valid=%b data=%h ch=%0d want 1/d/3", out_valid, out_data, out_ch);
        end
        sel = 2'd2; in_valid = 4'b1011;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++; $display("FAIL fixed_noval_ready: got %b want 0000", in_ready);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_data !== 4'hD || out_ch !== 2'd3) begin
            errors++;
            $display("FAIL fixed_drop: got valid=%b data=%h ch=%0d want 0/d/3", out_valid, out_data, out_ch);
        end
    endtask

    task automatic test_rr_wrap();
`ifdef STREAM_MUX_BURST_EN
        int exp_ch[6] = '{0, 0, 0, 1, 1, 1};
`else
        int exp_ch[6] = '{0, 1, 2, 3, 0, 1};
`endif
        do_reset();
        mode = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
        in_data = {4'd4, 4'd3, 4'd2, 4'd1};
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (in_ready !== 4'(1 << exp_ch[i])) begin
                errors++; $display("FAIL rr_ready[%0d]: got %b want ch %0d", i, in_ready, exp_ch[i]);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || int'(out_ch) != exp_ch[i] || int'(out_data) != exp_ch[i] + 1) begin
                errors++;
                $display("FAIL rr_beat[%0d]: got valid=%b data=%0d ch=%0d want 1/%0d/%0d",
                         i, out_valid, out_data, out_ch, exp_ch[i] + 1, exp_ch[i]);
            end
        end
    endtask

    task automatic test_sparse();
`ifdef STREAM_MUX_BURST_EN
        int exp_ch[4] = '{1, 1, 1, 3};
`else
        int exp_ch[4] = '{1, 3, 1, 3};
`endif
        do_reset();
        mode = 1'b1; out_ready = 1'b1; in_valid = 4'b1010;
        in_data = {4'h7, 4'h6, 4'h5, 4'h4};
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ((in_ready & 4'b0101) !== 4'b0000 || in_ready !== m_ready()) begin
                errors++; $display("FAIL sparse_ready[%0d]: got %b want %b", i, in_ready, m_ready());
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || int'(out_ch) != exp_ch[i]) begin
                errors++; $display("FAIL sparse_ch[%0d]: got ch=%0d want %0d", i, out_ch, exp_ch[i]);
            end
        end
    endtask

    task automatic test_burst();
`ifdef STREAM_MUX_BURST_EN
        int exp_ch[$] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
`else
        int exp_ch[$] = '{0, 1, 2, 3, 0};
`endif
        do_reset();
        mode = 1'b1; out_ready = 1'b1; in_valid = 4'b1111;
        in_data = {4'd4, 4'd3, 4'd2, 4'd1};
        foreach (exp_ch[i]) begin
            #1;
            tick();
            checks++;
            if (out_valid !== 1'b1 || int'(out_ch) != exp_ch[i]) begin
                errors++; $display("FAIL burst_ch[%0d]: got ch=%0d want %0d", i, out_ch, exp_ch[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [5:0] exp_q[$];
        int per[N] = '{0, 0, 0, 0};
        int sent = 0, recv = 0, stall_left = 0;
        bit stalled = 0;
        do_reset();
        mode = 1'b1; in_valid = 4'b1111;
        for (int c = 0; c < N; c++) in_data[c] = 4'(c * 4);
        for (int cyc = 0; cyc < 100 && recv < 16; cyc++) begin
            out_ready = (stall_left == 0);
            #1;
            checks++;
            if (in_ready !== m_ready()) begin
                errors++; $display("FAIL bp_ready: got %b want %b", in_ready, m_ready());
            end
            if (!out_ready) begin
                checks++;
                if (in_ready !== 4'b0000 || out_valid !== 1'b1 || {out_ch, out_data} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL bp_hold: got ready=%b valid=%b ch/data=%h want 0000/1/%h",
                             in_ready, out_valid, {out_ch, out_data}, exp_q[0]);
                end
                stall_left--;
            end else if (exp_q.size() > 0) begin
                checks++;
                if (out_valid !== 1'b1 || {out_ch, out_data} !== exp_q[0]) begin
                    errors++;
                    $display("FAIL bp_beat: got valid=%b ch/data=%h want 1/%h", out_valid, {out_ch, out_data}, exp_q[0]);
                end
                void'(exp_q.pop_front());
                recv++;
            end
            tick();
            if (m_last >= 0) begin
                exp_q.push_back({2'(m_last), in_data[m_last]});
                sent++;
                per[m_last]++;
                in_data[m_last] = 4'(m_last * 4 + per[m_last]);
                if (per[m_last] == 4) in_valid[m_last] = 1'b0;
            end
            if (sent == 1 && !stalled) begin
                stalled = 1;
                stall_left = 3;
            end
        end
        checks++;
        if (sent != 16 || recv != 16) begin
            errors++; $display("FAIL bp_count: got sent=%0d recv=%0d want 16/16", sent, recv);
        end
        out_ready = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            reset_n   = ($urandom_range(0, 24) != 0);
            mode      = 1'($urandom_range(0, 1));
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            #1;
            checks++;
            if (in_ready !== m_ready()) begin
                errors++; $display("FAIL rand_ready[%0d]: got %b want %b", i, in_ready, m_ready());
            end
            tick();
            checks++;
            if ({out_valid, out_ch, out_data} !== {m_valid, 2'(m_ch), m_data}) begin
                errors++;
                $display("FAIL rand_out[%0d]: got valid=%b ch=%0d data=%h want %b/%0d/%h",
                         i, out_valid, out_ch, out_data, m_valid, m_ch, m_data);
            end
        end
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_rr_wrap();
        test_sparse();
        test_burst();
        test_backpressure();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
